// File: rtl/mmio_sig_monitor.sv
// mmio_sig_monitor: snoops MMIO writes into per-channel signature records and runs a stop/drain/done sequence
module mmio_sig_monitor #(
  parameter int                DATA_W       = 64,
  parameter int                ADDR_W       = 32,
  parameter int                NUM_CH       = 4,
  parameter int                DEPTH        = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h6000_0000,
  parameter int                STRIDE       = 8,
  parameter int                STOP_CH      = 0,
  parameter int                DRAIN_CYCLES = 500
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mmio_req_i,
  input  logic                      mmio_we_i,
  input  logic [ADDR_W-1:0]         mmio_addr_i,
  input  logic [DATA_W-1:0]         mmio_wdata_i,
  input  logic [DATA_W-1:0]         mmio_wdata_t0_i,
  input  logic [ADDR_W-1:0]         mmio_addr_t0_i,
  input  logic                      mmio_req_t0_i,
  input  logic [31:0]               simlen_i,
  input  logic [NUM_CH-1:0]         ch_en_i,
  output logic                      rec_valid_o,
  input  logic                      rec_ready_i,
  output logic [$clog2(NUM_CH)-1:0] rec_ch_o,
  output logic [15:0]               rec_idx_o,
  output logic [DATA_W-1:0]         rec_data_o,
  output logic [DATA_W-1:0]         rec_data_t0_o,
  output logic                      rec_ctrl_taint_o,
  output logic                      stop_seen_o,
  output logic                      done_o,
  output logic                      overflow_o,
  output logic [31:0]               cycle_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = CW + 16 + 2 * DATA_W + 1;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t          state_q, state_d;
  logic [31:0]     drain_q;
  logic [15:0]     idx_q [NUM_CH];
  logic [RW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic [CW-1:0]   hit_ch;
  logic            hit, stop_hit, run, sim_end, full, pop, push, accept;
  always_comb begin
    hit = 1'b0;
    stop_hit = 1'b0;
    hit_ch = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (mmio_req_i && mmio_we_i && ch_en_i[i] && mmio_addr_i == BASE_ADDR + ADDR_W'(STRIDE * i)) begin
        if (i == STOP_CH) stop_hit = 1'b1;
        else begin
          hit = 1'b1;
          hit_ch = CW'(i);
        end
      end
  end
  assign run         = state_q == RUN;
  assign sim_end     = simlen_i != 32'd0 && cycle_o == simlen_i - 32'd1;
  assign full        = count == (PW+1)'(DEPTH);
  assign rec_valid_o = count != '0;
  assign pop         = rec_valid_o & rec_ready_i;
  assign push        = run & hit;
  assign accept      = push & (~full | pop);
  assign done_o      = state_q == DONE;
  // Data outputs read straight from the head slot; gated so an empty FIFO shows zeros
  assign {rec_ch_o, rec_idx_o, rec_data_o, rec_data_t0_o, rec_ctrl_taint_o} = rec_valid_o ? mem[rd_ptr] : '0;
  always_comb begin
    state_d = run ? (sim_end ? DONE : stop_hit ? DRAIN : RUN)
                  : (state_q == DRAIN && drain_q == 32'd0) ? DONE : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      cycle_o     <= '0;
      drain_q     <= '0;
      stop_seen_o <= 1'b0;
      overflow_o  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < NUM_CH; i++) idx_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != DONE) cycle_o <= cycle_o + 32'd1;
      if (run && stop_hit) begin
        stop_seen_o <= 1'b1;
        drain_q     <= 32'(DRAIN_CYCLES);
      end else if (state_q == DRAIN && drain_q != 32'd0) drain_q <= drain_q - 32'd1;
      // Sequence numbers advance even when the record itself is dropped
      if (push) idx_q[hit_ch] <= idx_q[hit_ch] + 16'd1;
      if (push && full && !pop) overflow_o <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(accept) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) mem[wr_ptr] <= {hit_ch, idx_q[hit_ch], mmio_wdata_i, mmio_wdata_t0_i, mmio_req_t0_i | (|mmio_addr_t0_i)};
  end
endmodule
